lane_memory: RTL

LANE_MEMORY -- requirements
Module: lane_memory

---
 rtl/lane_memory.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lane_memory.sv
// Lane-addressable single-port word memory with 1-cycle registered reads,
// per-lane writes, pair-expand / extract special loads and a zero-fill
// sweep that runs after reset.
module lane_memory #(
    parameter int unsigned LANES          = 4,
    parameter int unsigned LANE_W         = 8,
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ,
    input  logic [ADDR_W-1:0]          A,
    input  logic [LANES*LANE_W-1:0]    WDV,
    input  logic [LANES*LANE_W-1:0]    WDS,
    input  logic [$clog2(LANES)-1:0]   POS,
    input  logic                       WE,
    input  logic                       E,
    input  logic                       S,
    output logic [LANES*LANE_W-1:0]    RD,
    output logic                       RVALID,
    output logic                       BUSY
);

    localparam int unsigned W      = LANES * LANE_W;
    localparam int unsigned HALF   = LANES / 2;
    localparam int unsigned PW     = $clog2(LANES);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [W-1:0]        rd_q;
    logic                rvalid_q;
    logic [W-1:0]        mem_q [DEPTH];

    logic                accept_c;
    logic [W-1:0]        word_c;
    logic [LANE_W-1:0]   lanes_c [LANES];
    logic [PW-1:0]       pair_lo_c;
    logic [PW-1:0]       pair_hi_c;
    logic [W-1:0]        rdata_c;
    logic                unused_c;

    // Requests are only honoured once the clear sweep has finished.
    assign accept_c = REQ && (state_q == ST_IDLE);

    // Split the addressed word into its lanes.
    assign word_c = mem_q[A];
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lanes_c[k] = word_c[k*LANE_W +: LANE_W];
    end

    // Lane pair selected by POS for the expand load: lanes 2*POS and 2*POS+1.
    assign pair_lo_c = PW'({POS, 1'b0});
    assign pair_hi_c = pair_lo_c | PW'(1);

    // Read-data formatting for plain, extract and pair-expand loads.
    always_comb begin
        rdata_c = '0;
        if (!S) begin
            rdata_c = word_c;
        end else if (E) begin
            rdata_c = W'(lanes_c[POS]);
        end else if (!POS[PW-1]) begin
            rdata_c = {{HALF{lanes_c[pair_hi_c]}}, {HALF{lanes_c[pair_lo_c]}}};
        end
    end

    // Clear FSM, sweep counter and registered read port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= CLEAR_ON_RESET ? ST_SWEEP : ST_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_SWEEP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (accept_c && !WE) begin
                rd_q     <= rdata_c;
                rvalid_q <= 1'b1;
            end
        end
    end

    // Storage: sweep zero-fill, or full-word / single-lane writes via lane enables.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == ST_SWEEP) begin
                mem_q[cnt_q[ADDR_W-1:0]] <= '0;
            end else if (REQ && WE) begin
                for (int k = 0; k < LANES; k++) begin
                    if (!E || (POS == PW'(k))) begin
                        mem_q[A][k*LANE_W +: LANE_W] <= E ? WDS[LANE_W-1:0]
                                                          : WDV[k*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Only the low lane of the scalar write data is meaningful.
    assign unused_c = ^WDS[W-1:LANE_W];

    assign RD     = rd_q;
    assign RVALID = rvalid_q;
    assign BUSY   = (state_q == ST_SWEEP);

endmodule
